// File: rtl/tally_pkg.sv
// Shared constants for the wrap tally: counter limits, BCD bounds and
// seven-segment patterns in {g,f,e,d,c,b,a} order, active-high.
package tally_pkg;

    localparam logic [3:0] LAST_COUNT = 4'd6;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to seven-segment decode; non-BCD codes blank the digit.
module seg7_decoder
    import tally_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/wrap_tally_display.sv
// Counts 6->0 wraps of the upstream mod-7 counter into a two-digit BCD tally
// and scans it onto a multiplexed two-digit seven-segment display.
module wrap_tally_display
    import tally_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count_in,
    input  logic       clr,
    output logic [3:0] tally_ones,
    output logic [3:0] tally_tens,
    output logic       wrap_pulse,
    output logic       ovf,
    output logic       err,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int                SCAN_W    = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic [3:0]        prev;
    logic              prev_vld;
    bcd2_t             tally;
    logic              wrap_hit;
    logic              tally_full;
    logic [SCAN_W-1:0] scan_cnt;
    logic              sel;
    logic [3:0]        digit_sel;

    function automatic bcd2_t bcd_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.ones == BCD_MAX) begin
            r.ones = 4'd0;
            r.tens = (v.tens == BCD_MAX) ? 4'd0 : v.tens + 4'd1;
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

    // prev_vld masks the first cycle after reset so a stale prev can never wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev     <= 4'd0;
            prev_vld <= 1'b0;
        end else begin
            prev     <= count_in;
            prev_vld <= 1'b1;
        end
    end

    assign wrap_hit   = prev_vld && (prev == LAST_COUNT) && (count_in == 4'd0);
    assign tally_full = (tally.ones == BCD_MAX) && (tally.tens == BCD_MAX);

    // clr outranks a coincident wrap for the tally, but the pulse still fires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tally      <= '0;
            wrap_pulse <= 1'b0;
            ovf        <= 1'b0;
            err        <= 1'b0;
        end else begin
            wrap_pulse <= wrap_hit;
            if (clr) begin
                tally <= '0;
                ovf   <= 1'b0;
                err   <= 1'b0;
            end else begin
                if (wrap_hit) begin
                    tally <= bcd_inc(tally);
                    if (tally_full) begin
                        ovf <= 1'b1;
                    end
                end
                if (count_in > LAST_COUNT) begin
                    err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            sel      <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            sel      <= ~sel;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    assign digit_sel  = sel ? tally.tens : tally.ones;
    assign an         = sel ? 2'b01 : 2'b10;
    assign tally_ones = tally.ones;
    assign tally_tens = tally.tens;

    seg7_decoder u_dec (
        .digit (digit_sel),
        .seg   (seg)
    );

endmodule

// File: tb/tb_wrap_tally_display.sv
// Scoreboard bench for wrap_tally_display: stimulus queues expected wraps and
// probes, a negedge monitor pops and compares them against the DUT.
module tb_wrap_tally_display;

    localparam int SCAN_DIV = 4;
    localparam logic [3:0] M_T = 4'b0001, M_F = 4'b0010, M_D = 4'b0100, M_W = 4'b1000;
    localparam logic [3:0] M_ALL = 4'b1111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] count_in = 4'd0;
    logic [3:0] tally_ones, tally_tens;
    logic       wrap_pulse, ovf, err;
    logic [6:0] seg;
    logic [1:0] an;

    wrap_tally_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .clr        (clr),
        .tally_ones (tally_ones),
        .tally_tens (tally_tens),
        .wrap_pulse (wrap_pulse),
        .ovf        (ovf),
        .err        (err),
        .seg        (seg),
        .an         (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ones;
        logic [3:0] tens;
        logic       ovf;
        int         due;
    } wrap_t;

    typedef struct {
        string      name;
        logic [3:0] mask;
        logic [3:0] ones;
        logic [3:0] tens;
        logic       wp;
        logic       ovf;
        logic       err;
        logic [1:0] an;
        logic [6:0] seg;
    } probe_t;

    wrap_t  wq[$];
    probe_t pq[$];

    int  cyc = 0;
    int  n_run = 0;
    int  n_fail = 0;
    bit  done_req = 1'b0;

    // stimulus-side model state
    int         n_edges = 0;
    logic [3:0] m_prev = 4'd0;
    logic       m_vld = 1'b0;
    logic [3:0] m_ones = 4'd0, m_tens = 4'd0;
    logic       m_ovf = 1'b0;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [3:0] mask, input logic [3:0] o,
                       input logic [3:0] t, input logic wp, input logic ov, input logic er);
        probe_t p;
        bit     s;
        s = ((n_edges / SCAN_DIV) % 2) == 1;
        p.name = name; p.mask = mask; p.ones = o; p.tens = t;
        p.wp = wp; p.ovf = ov; p.err = er;
        p.an  = s ? 2'b01 : 2'b10;
        p.seg = seg_of(s ? t : o);
        pq.push_back(p);
    endtask

    task automatic drive(input logic [3:0] v, input logic c);
        logic hit;
        @(posedge clk); #1;
        n_edges++;
        count_in = v;
        clr = c;
        hit = m_vld && (m_prev == 4'd6) && (v == 4'd0);
        if (c) begin
            m_ones = 4'd0; m_tens = 4'd0; m_ovf = 1'b0;
        end else if (hit) begin
            if (m_ones == 4'd9) begin
                m_ones = 4'd0;
                if (m_tens == 4'd9) begin
                    m_tens = 4'd0;
                    m_ovf  = 1'b1;
                end else begin
                    m_tens = m_tens + 4'd1;
                end
            end else begin
                m_ones = m_ones + 4'd1;
            end
        end
        if (hit) wq.push_back('{ones: m_ones, tens: m_tens, ovf: m_ovf, due: cyc + 1});
        m_prev = v;
        m_vld  = 1'b1;
    endtask

    task automatic reset_dut(input int ncyc, input bit probe_async);
        @(posedge clk); #1;
        rst = 1'b1; clr = 1'b0; count_in = 4'd0;
        n_edges = 0; m_ones = 4'd0; m_tens = 4'd0; m_ovf = 1'b0;
        m_prev = 4'd0; m_vld = 1'b0;
        if (probe_async) begin
            #1;
            chk("async_reset", M_ALL, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        end
        repeat (ncyc) @(posedge clk);
        #1;
        rst = 1'b0;
        m_prev = count_in;
        m_vld  = 1'b1;
    endtask

    task automatic wrap_once();
        drive(4'd6, 1'b0);
        drive(4'd0, 1'b0);
    endtask

    initial begin : monitor
        wrap_t  w;
        probe_t p;
        forever begin
            @(negedge clk);
            if (wrap_pulse === 1'b1) begin
                n_run++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_wrap cyc=%0d: got pulse, required none", cyc);
                end else begin
                    w = wq.pop_front();
                    if (w.due != cyc || tally_ones !== w.ones || tally_tens !== w.tens || ovf !== w.ovf) begin
                        n_fail++;
                        $display("FAIL wrap cyc=%0d: got tally=%0d%0d ovf=%b, required tally=%0d%0d ovf=%b at cyc=%0d",
                                 cyc, tally_tens, tally_ones, ovf, w.tens, w.ones, w.ovf, w.due);
                    end
                end
            end
            while (wq.size() > 0 && wq[0].due < cyc) begin
                w = wq.pop_front();
                n_run++;
                n_fail++;
                $display("FAIL missed_wrap: got no pulse by cyc=%0d, required pulse at cyc=%0d", cyc, w.due);
            end
            while (pq.size() > 0) begin
                p = pq.pop_front();
                if (p.mask[0]) begin
                    n_run++;
                    if ({tally_tens, tally_ones} !== {p.tens, p.ones}) begin
                        n_fail++;
                        $display("FAIL %s tally: got %0d%0d required %0d%0d", p.name, tally_tens, tally_ones, p.tens, p.ones);
                    end
                end
                if (p.mask[1]) begin
                    n_run++;
                    if ({ovf, err} !== {p.ovf, p.err}) begin
                        n_fail++;
                        $display("FAIL %s flags: got ovf=%b err=%b required ovf=%b err=%b", p.name, ovf, err, p.ovf, p.err);
                    end
                end
                if (p.mask[2]) begin
                    n_run++;
                    if ({an, seg} !== {p.an, p.seg}) begin
                        n_fail++;
                        $display("FAIL %s display: got an=%b seg=%b required an=%b seg=%b", p.name, an, seg, p.an, p.seg);
                    end
                end
                if (p.mask[3]) begin
                    n_run++;
                    if (wrap_pulse !== p.wp) begin
                        n_fail++;
                        $display("FAIL %s wrap_pulse: got %b required %b", p.name, wrap_pulse, p.wp);
                    end
                end
            end
            if (done_req) begin
                n_run++;
                if (wq.size() != 0) begin
                    n_fail++;
                    $display("FAIL pending_wraps: got %0d outstanding, required 0", wq.size());
                end
                $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
                $finish;
            end
            if (cyc > 20000) begin
                n_fail++;
                $display("FAIL watchdog: got cyc=%0d, required completion before 20000", cyc);
                $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
                $fatal(1, "watchdog expired");
            end
        end
    end

    initial begin : stimulus
        reset_dut(3, 1'b0);
        chk("reset", M_ALL, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // free-running 0..6 sequence: ten wraps seven cycles apart
        for (int i = 0; i <= 70; i++) drive(4'(i % 7), 1'b0);
        drive(4'd1, 1'b0);
        chk("tally10", M_T | M_F, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0);

        // preload 99, then roll over into 00 with ovf
        drive(4'd1, 1'b1);
        drive(4'd1, 1'b0);
        chk("clr_tally", M_T | M_F, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 99; k++) wrap_once();
        drive(4'd1, 1'b0);
        chk("tally99", M_T | M_F, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
        wrap_once();
        drive(4'd1, 1'b0);
        chk("rollover", M_T | M_F, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        drive(4'd2, 1'b0);
        drive(4'd3, 1'b0);
        chk("ovf_sticky", M_T | M_F, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        drive(4'd3, 1'b1);
        drive(4'd4, 1'b0);
        chk("ovf_clr", M_T | M_F, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // 6 -> 7 -> 0 is not a wrap, and 7 raises err
        drive(4'd6, 1'b0);
        drive(4'd7, 1'b0);
        drive(4'd0, 1'b0);
        chk("err_set", M_T | M_F, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        drive(4'd1, 1'b0);
        chk("no_wrap_7_0", M_T | M_F | M_W, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        drive(4'd1, 1'b1);
        drive(4'd2, 1'b0);
        chk("err_clr", M_T | M_F, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // clr coincident with a wrap at tally 05
        for (int k = 0; k < 5; k++) wrap_once();
        drive(4'd6, 1'b0);
        chk("tally05", M_T, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0);
        drive(4'd0, 1'b1);
        drive(4'd1, 1'b0);
        chk("clr_wins", M_T | M_W, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        drive(4'd2, 1'b0);
        chk("pulse_one_cycle", M_W, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // async reset mid-count with prev=6, released with count_in=0
        wrap_once();
        drive(4'd1, 1'b0);
        chk("tally01", M_T, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
        drive(4'd6, 1'b0);
        reset_dut(2, 1'b1);
        chk("post_reset", M_ALL, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        drive(4'd0, 1'b0);
        drive(4'd1, 1'b0);
        chk("no_wrap_after_reset", M_T | M_W, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // display scan at tally 37
        drive(4'd1, 1'b1);
        for (int k = 0; k < 37; k++) wrap_once();
        drive(4'd1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            drive(4'd1, 1'b0);
            chk("scan37", M_T | M_D, 4'd7, 4'd3, 1'b0, 1'b0, 1'b0);
        end

        drive(4'd1, 1'b0);
        done_req = 1'b1;
        #200;
        $display("FAIL monitor_stall: got no summary, required summary from monitor");
        $fatal(1, "monitor did not finish");
    end

endmodule
